// File: rtl/bin_search_engine_pkg.sv
// Shared types and helpers for the binary search engine.
package bin_search_pkg;

    localparam int MAX_ADDR_W = 16;

    typedef enum logic [2:0] {IDLE, CALC, WAIT, COMPARE, DONE} state_t;

    // Midpoint of [lo, hi]; the extra sum bit keeps lo+hi from overflowing.
    function automatic logic [MAX_ADDR_W-1:0] next_mid(input logic [MAX_ADDR_W-1:0] lo,
                                                       input logic [MAX_ADDR_W-1:0] hi);
        logic [MAX_ADDR_W:0] sum;
        sum = {1'b0, lo} + {1'b0, hi};
        return sum[MAX_ADDR_W:1];
    endfunction

endpackage

// File: rtl/bin_search_engine.sv
// Binary search over an ascending-sorted synchronous RAM with configurable read latency.
module bin_search_engine
    import bin_search_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] target,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] index,
    output logic [ADDR_W:0]   probes
);

    localparam int WCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t              state, state_next;
    logic [DATA_W-1:0]   tgt;
    logic [ADDR_W-1:0]   lo, hi, mid;
    logic [WCNT_W-1:0]   wcnt;
    logic                eq, gt, at_lo, at_hi;

    assign mem_addr = mid;
    assign eq       = (tgt == mem_rdata);
    assign gt       = (tgt > mem_rdata);
    assign at_lo    = (mid == lo);
    assign at_hi    = (mid == hi);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CALC;
            end
            CALC: begin
                busy       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (wcnt == '0) state_next = COMPARE;
            end
            COMPARE: begin
                busy = 1'b1;
                // Bounds checks stop the search before lo/hi could wrap past 0 or the top index.
                if (eq)      state_next = DONE;
                else if (gt) state_next = at_hi ? DONE : CALC;
                else         state_next = at_lo ? DONE : CALC;
            end
            DONE: begin
                done = 1'b1;
                if (!start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Target is pure data: captured on acceptance, never reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) tgt <= target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lo     <= '0;
            hi     <= '0;
            mid    <= '0;
            wcnt   <= '0;
            found  <= 1'b0;
            index  <= '0;
            probes <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lo     <= '0;
                        hi     <= '1;
                        found  <= 1'b0;
                        index  <= '0;
                        probes <= '0;
                    end
                end
                CALC: begin
                    mid  <= ADDR_W'(next_mid(MAX_ADDR_W'(lo), MAX_ADDR_W'(hi)));
                    wcnt <= WCNT_W'(RD_LAT - 1);
                end
                WAIT: begin
                    if (wcnt != '0) wcnt <= wcnt - 1'b1;
                end
                COMPARE: begin
                    probes <= probes + 1'b1;
                    if (eq) begin
                        found <= 1'b1;
                        index <= mid;
                    end else if (gt) begin
                        if (!at_hi) lo <= mid + 1'b1;
                    end else begin
                        if (!at_lo) hi <= mid - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_search_engine.sv
// Scoreboard bench: four engine configurations searching the same table of odd numbers.
module tb_bin_search_engine;

    typedef struct {
        bit found;
        int index;
        int probes;
        int lat;
    } exp_t;

    function automatic int cfg_aw(int i);
        return (i == 3) ? 3 : 5;
    endfunction

    function automatic int cfg_rl(int i);
        case (i)
            1:       return 1;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] target;

    logic [3:0] busy_v, done_v, found_v, wrap_v;
    logic [5:0] index_v  [4];
    logic [6:0] probes_v [4];
    logic [5:0] addr_v   [4];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference search over mem[i] = 2i+1.
    function automatic exp_t model(int tgt, int aw, int rl);
        exp_t e;
        int lo, hi, mid, v;
        bit fin;
        e.found = 0; e.index = 0; e.probes = 0;
        lo = 0; hi = (1 << aw) - 1; fin = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            mid = (lo + hi) / 2;
            v   = 2 * mid + 1;
            e.probes++;
            if (v == tgt) begin
                e.found = 1; e.index = mid; fin = 1;
            end else if (tgt > v) begin
                if (mid == hi) fin = 1; else lo = mid + 1;
            end else begin
                if (mid == lo) fin = 1; else hi = mid - 1;
            end
        end
        e.lat = 1 + e.probes * (rl + 2);
        return e;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g
        localparam int AW = cfg_aw(gi);
        localparam int RL = cfg_rl(gi);

        logic [AW-1:0] mem_addr, index;
        logic [7:0]    mem_rdata;
        logic          busy, done, found;
        logic [AW:0]   probes;
        logic [7:0]    pipe [RL];

        exp_t q[$];
        exp_t e;
        int   cnt = 0;
        bit   counting = 0;
        bit   wrap_seen = 0;
        logic busy_d = 1'b0;
        logic done_d = 1'b0;

        always @(posedge clk) begin
            pipe[0] <= 8'({mem_addr, 1'b1});
            for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata = pipe[RL-1];

        bin_search_engine #(.DATA_W(8), .ADDR_W(AW), .RD_LAT(RL)) dut (
            .clk(clk), .reset(reset), .start(start), .target(target),
            .mem_addr(mem_addr), .mem_rdata(mem_rdata),
            .busy(busy), .done(done), .found(found),
            .index(index), .probes(probes)
        );

        assign busy_v[gi]   = busy;
        assign done_v[gi]   = done;
        assign found_v[gi]  = found;
        assign wrap_v[gi]   = wrap_seen;
        assign index_v[gi]  = 6'(index);
        assign probes_v[gi] = 7'(probes);
        assign addr_v[gi]   = 6'(mem_addr);

        always begin
            @(posedge clk);
            #1;
            if (reset) begin
                counting = 0;
            end else begin
                if (busy === 1'b1 && busy_d !== 1'b1) begin
                    counting  = 1;
                    cnt       = 1;
                    wrap_seen = 0;
                end else if (counting) begin
                    cnt++;
                end
                if (busy === 1'b1 && busy_d === 1'b1 && mem_addr == '1) wrap_seen = 1;
                if (busy === 1'b1 || done === 1'b1)
                    chk($sformatf("busy_done_excl[%0d]", gi), {31'd0, busy & done}, 0);
                if (done === 1'b1 && done_d !== 1'b1) begin
                    counting = 0;
                    if (q.size() == 0) begin
                        chk($sformatf("unexpected_done[%0d]", gi), 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("latency[%0d]", gi), cnt, e.lat);
                        chk($sformatf("found[%0d]", gi), {31'd0, found}, {31'd0, e.found});
                        chk($sformatf("probes[%0d]", gi), 32'(probes), e.probes);
                        if (e.found) chk($sformatf("index[%0d]", gi), 32'(index), e.index);
                    end
                end
            end
            busy_d = busy;
            done_d = done;
        end
    end

    task automatic push_exp(input int tgt);
        g[0].q.push_back(model(tgt, cfg_aw(0), cfg_rl(0)));
        g[1].q.push_back(model(tgt, cfg_aw(1), cfg_rl(1)));
        g[2].q.push_back(model(tgt, cfg_aw(2), cfg_rl(2)));
        g[3].q.push_back(model(tgt, cfg_aw(3), cfg_rl(3)));
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_busy[%0d]", tag, i),   {31'd0, busy_v[i]}, 0);
            chk($sformatf("%s_done[%0d]", tag, i),   {31'd0, done_v[i]}, 0);
            chk($sformatf("%s_found[%0d]", tag, i),  {31'd0, found_v[i]}, 0);
            chk($sformatf("%s_index[%0d]", tag, i),  32'(index_v[i]), 0);
            chk($sformatf("%s_probes[%0d]", tag, i), 32'(probes_v[i]), 0);
            chk($sformatf("%s_addr[%0d]", tag, i),   32'(addr_v[i]), 0);
        end
    endtask

    task automatic run_search(input int tgt, input bit pulse);
        int c;
        push_exp(tgt);
        target = 8'(tgt);
        start  = 1'b1;
        @(posedge clk); #1;
        target = ~8'(tgt);
        if (pulse) begin
            start = 1'b0;
            @(posedge clk); #1;
            start = 1'b1;
        end
        c = 0;
        while (done_v !== 4'hf && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        chk("done_timeout", {31'd0, done_v === 4'hf}, 1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("done_held", 32'(done_v), 32'hf);
        chk("no_restart", 32'(busy_v), 0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", 32'(done_v), 0);
        chk("idle_busy", 32'(busy_v), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        target = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run_search(31, 1'b1);
        chk("s31_found", {31'd0, found_v[0]}, 1);
        chk("s31_index", 32'(index_v[0]), 15);
        chk("s31_probes", 32'(probes_v[0]), 1);

        run_search(1, 1'b0);
        chk("s1_index", 32'(index_v[0]), 0);
        chk("s1_probes", 32'(probes_v[0]), 5);

        run_search(63, 1'b0);
        chk("s63_index", 32'(index_v[0]), 31);
        chk("s63_probes", 32'(probes_v[0]), 6);

        run_search(0, 1'b0);
        chk("s0_found", {31'd0, found_v[0]}, 0);
        chk("s0_probes", 32'(probes_v[0]), 5);
        for (int i = 0; i < 4; i++) chk($sformatf("s0_nowrap[%0d]", i), {31'd0, wrap_v[i]}, 0);

        run_search(64, 1'b0);
        chk("s64_found", {31'd0, found_v[0]}, 0);
        chk("s64_probes", 32'(probes_v[0]), 6);

        run_search(32, 1'b0);
        chk("s32_found", {31'd0, found_v[0]}, 0);

        run_search(3, 1'b0);
        chk("s3_index", 32'(index_v[0]), 1);

        // Abort a search in the wait phase of its second probe.
        target = 8'd63;
        start  = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_mid_probes", 32'(probes_v[0]), 1);
        chk("abort_mid_busy", {31'd0, busy_v[0]}, 1);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check_cleared("abort");
        reset = 1'b0;
        @(posedge clk); #1;

        run_search(45, 1'b0);
        chk("s45_found", {31'd0, found_v[0]}, 1);
        chk("s45_index", 32'(index_v[0]), 22);

        for (int i = 0; i < 4; i++) begin
            case (i)
                0: chk("sb_drain[0]", g[0].q.size(), 0);
                1: chk("sb_drain[1]", g[1].q.size(), 0);
                2: chk("sb_drain[2]", g[2].q.size(), 0);
                default: chk("sb_drain[3]", g[3].q.size(), 0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
